// File: rtl/fsab_initiator_if.sv
// fsab_initiator_if
//   Groups every non-clock signal of the FSAB initiator: the client request
//   channel, the client write-data channel, the outbound fsabo bus (with its
//   credit return), the inbound fsabi read-return bus, the client read
//   return and the status outputs.
//
//   modport master : the initiator itself (drives req_ready, wdata_pop,
//                    fsabo_*, rd_*, err_unexpected, idle)
//   modport slave  : the environment around it (client + bus far end)
interface fsab_initiator_if;
    // client request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [30:0] req_addr;
    logic [3:0]  req_len;
    logic [3:0]  req_subdid;
    // client write data
    logic        wdata_valid;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        wdata_pop;
    // outbound fsabo bus
    logic        fsabo_valid;
    logic        fsabo_mode;
    logic [3:0]  fsabo_did;
    logic [3:0]  fsabo_subdid;
    logic [30:0] fsabo_addr;
    logic [3:0]  fsabo_len;
    logic [63:0] fsabo_data;
    logic [7:0]  fsabo_mask;
    logic        fsabo_credit;
    // inbound fsabi read returns
    logic        fsabi_valid;
    logic [3:0]  fsabi_did;
    logic [3:0]  fsabi_subdid;
    logic [63:0] fsabi_data;
    // client read return
    logic        rd_valid;
    logic [63:0] rd_data;
    logic [3:0]  rd_subdid;
    logic        rd_last;
    // status
    logic        err_unexpected;
    logic        idle;

    modport master (
        input  req_valid, req_write, req_addr, req_len, req_subdid,
        input  wdata_valid, wdata, wmask,
        input  fsabo_credit,
        input  fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
        output req_ready, wdata_pop,
        output fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
        output fsabo_addr, fsabo_len, fsabo_data, fsabo_mask,
        output rd_valid, rd_data, rd_subdid, rd_last,
        output err_unexpected, idle
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, req_subdid,
        output wdata_valid, wdata, wmask,
        output fsabo_credit,
        output fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
        input  req_ready, wdata_pop,
        input  fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
        input  fsabo_addr, fsabo_len, fsabo_data, fsabo_mask,
        input  rd_valid, rd_data, rd_subdid, rd_last,
        input  err_unexpected, idle
    );
endinterface

// File: rtl/fsab_initiator.sv
// fsab_initiator
//   Master-side FSAB request issuer. Accepts read/write burst requests from
//   a local client, spends one receiver RFIF credit per request, serialises
//   write data beats onto fsabo, and returns fsabi read beats tagged with
//   this initiator's DID to the client with burst framing (rd_last).
//
//   Parameters
//     DID             : device ID driven on fsabo_did and matched on fsabi_did
//     INITIAL_CREDITS : receiver RFIF depth, credit counter reset value
//     RLEN_DEPTH      : depth of the outstanding-read length FIFO (power of 2)
//   Ports
//     clk  : clock
//     Nrst : asynchronous active-low reset
//     bus  : fsab_initiator_if.master (request, write data, fsabo, fsabi,
//            read return and status signals)
module fsab_initiator #(
    parameter logic [3:0]  DID             = 4'd0,
    parameter int unsigned INITIAL_CREDITS = 4,
    parameter int unsigned RLEN_DEPTH      = 4
) (
    input logic               clk,
    input logic               Nrst,
    fsab_initiator_if.master  bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_WBURST = 1'b1;

    localparam int unsigned PW        = (RLEN_DEPTH > 1) ? $clog2(RLEN_DEPTH) : 1;
    localparam logic [2:0]  CR_INIT   = 3'(INITIAL_CREDITS);
    localparam logic [PW:0] RLEN_FULL = (PW + 1)'(RLEN_DEPTH);

    logic [0:0]  state;
    logic [3:0]  rem;
    logic [2:0]  cr;

    logic        ready;
    logic        accept;
    logic        accept_rd;
    logic        accept_wr;
    logic        burst_beat;

    // outstanding-read length FIFO
    logic [3:0]  rlen_mem [RLEN_DEPTH];
    logic [PW-1:0] rlen_wr_ptr;
    logic [PW-1:0] rlen_rd_ptr;
    logic [PW:0] rlen_cnt;
    logic        rlen_empty;
    logic        rlen_full;
    logic [3:0]  rlen_head;

    // read return tracking
    logic [3:0]  bc;
    logic [3:0]  bc_next;
    logic        rd_match;
    logic        rd_take;
    logic        rd_end;

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    always_comb begin
        rlen_empty = (rlen_cnt == '0);
        rlen_full  = (rlen_cnt == RLEN_FULL);
        rlen_head  = rlen_mem[rlen_rd_ptr];

        // A write needs its first data word ready now; a read needs a free
        // slot to remember its length for return framing.
        ready = (state == ST_IDLE) && (cr != 3'd0) &&
                (bus.req_write ? bus.wdata_valid : !rlen_full);

        accept     = bus.req_valid && ready;
        accept_rd  = accept && !bus.req_write;
        accept_wr  = accept && bus.req_write;
        burst_beat = (state == ST_WBURST) && bus.wdata_valid;

        bus.req_ready = ready;
        bus.wdata_pop = accept_wr || burst_beat;
        bus.idle      = (state == ST_IDLE) && (cr == CR_INIT) && rlen_empty;
    end

    // ------------------------------------------------------------------
    // Write burst FSM and credit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state <= ST_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_wr && (bus.req_len != 4'd1)) begin
                        state <= ST_WBURST;
                        rem   <= bus.req_len - 4'd1;
                    end
                end
                ST_WBURST: begin
                    if (bus.wdata_valid) begin
                        rem <= rem - 4'd1;
                        // Returning to IDLE on the last pop lets the next
                        // request be accepted in the very next cycle.
                        if (rem == 4'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Credit is spent on the first beat of a request only.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            cr <= CR_INIT;
        end else begin
            case ({accept, bus.fsabo_credit})
                2'b10:   cr <= cr - 3'd1;
                2'b01:   cr <= cr + 3'd1;
                default: cr <= cr;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // fsabo beat register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            bus.fsabo_valid  <= 1'b0;
            bus.fsabo_mode   <= 1'b0;
            bus.fsabo_did    <= '0;
            bus.fsabo_subdid <= '0;
            bus.fsabo_addr   <= '0;
            bus.fsabo_len    <= '0;
            bus.fsabo_data   <= '0;
            bus.fsabo_mask   <= '0;
        end else begin
            if (accept) begin
                bus.fsabo_valid  <= 1'b1;
                bus.fsabo_mode   <= bus.req_write;
                bus.fsabo_did    <= DID;
                bus.fsabo_subdid <= bus.req_subdid;
                bus.fsabo_addr   <= bus.req_addr;
                bus.fsabo_len    <= bus.req_len;
                bus.fsabo_data   <= bus.req_write ? bus.wdata : '0;
                bus.fsabo_mask   <= bus.req_write ? bus.wmask : '0;
            end else if (burst_beat) begin
                // header fields stay as captured on the first beat
                bus.fsabo_valid <= 1'b1;
                bus.fsabo_data  <= bus.wdata;
                bus.fsabo_mask  <= bus.wmask;
            end else begin
                bus.fsabo_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read length FIFO
    // ------------------------------------------------------------------
    always_comb begin
        rd_match = bus.fsabi_valid && (bus.fsabi_did == DID);
        rd_take  = rd_match && !rlen_empty;
        bc_next  = bc + 4'd1;
        rd_end   = rd_take && (bc_next == rlen_head);
    end

    always_ff @(posedge clk) begin
        if (accept_rd) begin
            rlen_mem[rlen_wr_ptr] <= bus.req_len;
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            rlen_wr_ptr <= '0;
            rlen_rd_ptr <= '0;
            rlen_cnt    <= '0;
        end else begin
            if (accept_rd) begin
                rlen_wr_ptr <= rlen_wr_ptr + 1'b1;
            end
            if (rd_end) begin
                rlen_rd_ptr <= rlen_rd_ptr + 1'b1;
            end
            case ({accept_rd, rd_end})
                2'b10:   rlen_cnt <= rlen_cnt + 1'b1;
                2'b01:   rlen_cnt <= rlen_cnt - 1'b1;
                default: rlen_cnt <= rlen_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read return to client
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            bus.rd_valid       <= 1'b0;
            bus.rd_last        <= 1'b0;
            bus.rd_data        <= '0;
            bus.rd_subdid      <= '0;
            bus.err_unexpected <= 1'b0;
            bc                 <= '0;
        end else begin
            bus.rd_valid <= rd_take;
            bus.rd_last  <= rd_end;
            if (rd_take) begin
                bus.rd_data   <= bus.fsabi_data;
                bus.rd_subdid <= bus.fsabi_subdid;
                bc            <= rd_end ? 4'd0 : bc_next;
            end
            // A return for our DID with nothing outstanding is dropped and
            // flagged until the next reset.
            if (rd_match && rlen_empty) begin
                bus.err_unexpected <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fsab_initiator.sv
// tb_fsab_initiator
//   Self-checking bench for fsab_initiator: directed scenarios followed by a
//   randomized phase, every cycle compared against a transaction-level model
//   (credit count, queue of outstanding read lengths, remaining write beats).
module tb_fsab_initiator;
    localparam logic [3:0] DID  = 4'd0;
    localparam int         INIT = 4;
    localparam int         RDEP = 4;

    logic clk  = 1'b0;
    logic Nrst = 1'b1;

    fsab_initiator_if bus ();

    fsab_initiator #(
        .DID(DID),
        .INITIAL_CREDITS(INIT),
        .RLEN_DEPTH(RDEP)
    ) dut (
        .clk(clk),
        .Nrst(Nrst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int   m_cr;
    bit   m_busy;
    int   m_rem;
    int   m_rlen[$];
    int   m_bc;
    bit   m_err;
    int   pend;      // read beats the bench still owes the DUT

    // expected registered outputs
    bit          e_fv;
    bit          e_mode;
    logic [30:0] e_addr;
    logic [3:0]  e_len;
    logic [3:0]  e_sub;
    logic [63:0] e_data;
    logic [7:0]  e_mask;
    bit          e_rdv;
    bit          e_last;
    logic [63:0] e_rdata;
    logic [3:0]  e_rsub;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (Nrst && bus.req_valid && bus.req_ready) begin
            assert (bus.req_len != 4'd0)
            else $error("FAIL req_len_zero: request issued with length 0");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_cr   = INIT;
        m_busy = 0;
        m_rem  = 0;
        m_rlen.delete();
        m_bc   = 0;
        m_err  = 0;
        pend   = 0;
        e_fv   = 0;
        e_rdv  = 0;
        e_last = 0;
    endtask

    task automatic clear_inputs();
        bus.req_valid    = 0;
        bus.req_write    = 0;
        bus.req_addr     = '0;
        bus.req_len      = 4'd1;
        bus.req_subdid   = '0;
        bus.wdata_valid  = 0;
        bus.wdata        = '0;
        bus.wmask        = '0;
        bus.fsabo_credit = 0;
        bus.fsabi_valid  = 0;
        bus.fsabi_did    = '0;
        bus.fsabi_subdid = '0;
        bus.fsabi_data   = '0;
    endtask

    task automatic set_req(input bit w, input logic [30:0] a, input logic [3:0] l, input logic [3:0] s);
        bus.req_valid  = 1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_len    = l;
        bus.req_subdid = s;
    endtask

    // one own-DID read return beat for an outstanding read
    task automatic drive_ret();
        bus.fsabi_valid  = 1;
        bus.fsabi_did    = DID;
        bus.fsabi_subdid = 4'($urandom);
        bus.fsabi_data   = {$urandom, $urandom};
        pend--;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check registered outputs just after the edge.
    task automatic tick();
        bit ready, acc, pop, match;
        @(negedge clk);
        ready = !m_busy && (m_cr != 0) &&
                (bus.req_write ? bus.wdata_valid : (m_rlen.size() < RDEP));
        acc = bus.req_valid && ready;
        pop = (acc && bus.req_write) || (m_busy && bus.wdata_valid);
        check("req_ready", 64'(bus.req_ready), 64'(ready));
        check("wdata_pop", 64'(bus.wdata_pop), 64'(pop));
        check("idle", 64'(bus.idle), 64'(!m_busy && m_cr == INIT && m_rlen.size() == 0));

        match  = bus.fsabi_valid && (bus.fsabi_did == DID);
        e_rdv  = 0;
        e_last = 0;
        if (match) begin
            if (m_rlen.size() == 0) begin
                m_err = 1;
            end else begin
                e_rdv   = 1;
                e_rdata = bus.fsabi_data;
                e_rsub  = bus.fsabi_subdid;
                m_bc++;
                if (m_bc == m_rlen[0]) begin
                    e_last = 1;
                    void'(m_rlen.pop_front());
                    m_bc = 0;
                end
            end
        end

        if (acc) begin
            e_fv   = 1;
            e_mode = bus.req_write;
            e_addr = bus.req_addr;
            e_len  = bus.req_len;
            e_sub  = bus.req_subdid;
            e_data = bus.req_write ? bus.wdata : 64'd0;
            e_mask = bus.req_write ? bus.wmask : 8'd0;
            if (bus.req_write) begin
                m_rem  = int'(bus.req_len) - 1;
                m_busy = (m_rem > 0);
            end else begin
                m_rlen.push_back(int'(bus.req_len));
                pend += int'(bus.req_len);
            end
        end else if (m_busy && bus.wdata_valid) begin
            e_fv   = 1;
            e_data = bus.wdata;
            e_mask = bus.wmask;
            m_rem--;
            if (m_rem == 0) m_busy = 0;
        end else begin
            e_fv = 0;
        end
        m_cr = m_cr - (acc ? 1 : 0) + (bus.fsabo_credit ? 1 : 0);

        @(posedge clk);
        #1;
        check("fsabo_valid", 64'(bus.fsabo_valid), 64'(e_fv));
        if (e_fv) begin
            check("fsabo_mode",   64'(bus.fsabo_mode),   64'(e_mode));
            check("fsabo_did",    64'(bus.fsabo_did),    64'(DID));
            check("fsabo_subdid", 64'(bus.fsabo_subdid), 64'(e_sub));
            check("fsabo_addr",   64'(bus.fsabo_addr),   64'(e_addr));
            check("fsabo_len",    64'(bus.fsabo_len),    64'(e_len));
            check("fsabo_data",   bus.fsabo_data,        e_data);
            check("fsabo_mask",   64'(bus.fsabo_mask),   64'(e_mask));
        end
        check("rd_valid", 64'(bus.rd_valid), 64'(e_rdv));
        check("rd_last",  64'(bus.rd_last),  64'(e_last));
        if (e_rdv) begin
            check("rd_data",   bus.rd_data,          e_rdata);
            check("rd_subdid", 64'(bus.rd_subdid),   64'(e_rsub));
        end
        check("err_unexpected", 64'(bus.err_unexpected), 64'(m_err));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        Nrst = 0;
        #1;
        check("rst_fsabo_valid",  64'(bus.fsabo_valid),  64'd0);
        check("rst_fsabo_mode",   64'(bus.fsabo_mode),   64'd0);
        check("rst_fsabo_addr",   64'(bus.fsabo_addr),   64'd0);
        check("rst_fsabo_len",    64'(bus.fsabo_len),    64'd0);
        check("rst_fsabo_subdid", 64'(bus.fsabo_subdid), 64'd0);
        check("rst_fsabo_data",   bus.fsabo_data,        64'd0);
        check("rst_fsabo_mask",   64'(bus.fsabo_mask),   64'd0);
        check("rst_rd_valid",     64'(bus.rd_valid),     64'd0);
        check("rst_rd_last",      64'(bus.rd_last),      64'd0);
        check("rst_rd_data",      bus.rd_data,           64'd0);
        check("rst_rd_subdid",    64'(bus.rd_subdid),    64'd0);
        check("rst_err",          64'(bus.err_unexpected), 64'd0);
        check("rst_wdata_pop",    64'(bus.wdata_pop),    64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        Nrst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic restore_credits();
        clear_inputs();
        for (int i = 0; i < 2 * INIT && m_cr < INIT; i++) begin
            bus.fsabo_credit = 1;
            tick();
        end
        bus.fsabo_credit = 0;
    endtask

    task automatic drain_returns();
        clear_inputs();
        for (int i = 0; i < 64 && pend > 0; i++) begin
            drive_ret();
            tick();
            clear_inputs();
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #2;
        apply_reset();
        check("idle_after_reset", 64'(bus.idle), 64'd1);

        // single read, len 4, addr 0x100
        set_req(0, 31'h100, 4'd4, 4'd5);
        tick();
        clear_inputs();
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.fsabi_valid  = 1;
            bus.fsabi_did    = DID;
            bus.fsabi_subdid = 4'd5;
            bus.fsabi_data   = 64'(k) + 64'h1000;
            pend--;
            tick();
        end
        clear_inputs();
        tick();
        restore_credits();

        // write len 8 with data held valid: 8 contiguous beats
        set_req(1, 31'h200, 4'd8, 4'd2);
        bus.wdata_valid = 1;
        bus.wmask       = 8'hff;
        bus.wdata       = 64'd0;
        tick();
        bus.req_valid = 0;
        for (int k = 1; k < 8; k++) begin
            bus.wdata = 64'(k);
            tick();
        end
        clear_inputs();
        tick();
        restore_credits();

        // write len 3 with a two-cycle data gap
        set_req(1, 31'h300, 4'd3, 4'd1);
        bus.wdata_valid = 1;
        bus.wmask       = 8'h0f;
        bus.wdata       = 64'hA;
        tick();
        bus.req_valid = 0;
        bus.wdata     = 64'hB;
        tick();
        bus.wdata_valid = 0;
        tick();
        tick();
        bus.wdata_valid = 1;
        bus.wdata       = 64'hC;
        tick();
        clear_inputs();
        tick();
        restore_credits();

        // five reads with no credits returned
        for (int i = 0; i < 4; i++) begin
            set_req(0, 31'h400 + 31'(i), 4'd1, 4'(i));
            tick();
        end
        set_req(0, 31'h404, 4'd1, 4'd4);
        tick();
        tick();
        drive_ret();
        tick();
        bus.fsabi_valid  = 0;
        bus.fsabo_credit = 1;
        tick();
        bus.fsabo_credit = 0;
        tick();
        clear_inputs();
        drain_returns();
        restore_credits();

        // credit return coincident with issue at cr == 1
        for (int i = 0; i < 3; i++) begin
            set_req(1, 31'h500 + 31'(i), 4'd1, 4'd7);
            bus.wdata_valid = 1;
            bus.wdata       = 64'(i);
            tick();
        end
        bus.fsabo_credit = 1;
        tick();
        clear_inputs();
        tick();
        set_req(1, 31'h510, 4'd1, 4'd7);
        bus.wdata_valid = 1;
        tick();
        tick();
        clear_inputs();
        restore_credits();

        // own-DID return with nothing outstanding, then a foreign DID
        bus.fsabi_valid  = 1;
        bus.fsabi_did    = DID;
        bus.fsabi_data   = 64'hdead;
        tick();
        bus.fsabi_did = 4'd3;
        tick();
        clear_inputs();
        tick();
        check("err_sticky", 64'(bus.err_unexpected), 64'd1);

        // reset in the middle of a write burst (rem 5)
        set_req(1, 31'h600, 4'd8, 4'd9);
        bus.wdata_valid = 1;
        bus.wmask       = 8'h3c;
        tick();
        bus.req_valid = 0;
        tick();
        tick();
        apply_reset();
        tick();
        check("idle_after_burst_reset", 64'(bus.idle), 64'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid    = ($urandom_range(0, 99) < 40);
            bus.req_write    = 1'($urandom_range(0, 1));
            bus.req_addr     = 31'($urandom);
            bus.req_len      = 4'($urandom_range(1, 8));
            bus.req_subdid   = 4'($urandom);
            bus.wdata_valid  = ($urandom_range(0, 99) < 75);
            bus.wdata        = {$urandom, $urandom};
            bus.wmask        = 8'($urandom);
            bus.fsabo_credit = (m_cr < INIT) && ($urandom_range(0, 99) < 30);
            bus.fsabi_valid  = 0;
            if (pend > 0 && $urandom_range(0, 99) < 60) begin
                drive_ret();
            end else if ($urandom_range(0, 99) < 10) begin
                bus.fsabi_valid  = 1;
                bus.fsabi_did    = 4'($urandom_range(1, 15));
                bus.fsabi_subdid = 4'($urandom);
                bus.fsabi_data   = {$urandom, $urandom};
            end
            tick();
        end
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
